// File: rtl/dcache_arbiter.sv
// dcache_arbiter: arbitrates two LSU pipes onto a single data-cache port.
// One access outstanding at a time; pipe 0 (older) has priority. A flush
// cancels the in-flight access, and responses for cancelled accesses that
// the cache already took are swallowed in DROP.
module dcache_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  // pipe 0 (older)
  input  logic                p0_req_valid,
  output logic                p0_req_ready,
  input  logic [ADDR_W-1:0]   p0_addr,
  input  logic [DATA_W-1:0]   p0_wdata,
  input  logic [DATA_W/8-1:0] p0_wstrb,
  input  logic                p0_we,
  input  logic                p0_uncached,
  output logic                p0_resp_valid,
  output logic [DATA_W-1:0]   p0_rdata,
  // pipe 1 (younger)
  input  logic                p1_req_valid,
  output logic                p1_req_ready,
  input  logic [ADDR_W-1:0]   p1_addr,
  input  logic [DATA_W-1:0]   p1_wdata,
  input  logic [DATA_W/8-1:0] p1_wstrb,
  input  logic                p1_we,
  input  logic                p1_uncached,
  output logic                p1_resp_valid,
  output logic [DATA_W-1:0]   p1_rdata,
  // dcache port
  output logic                dc_req_valid,
  input  logic                dc_req_ready,
  output logic [ADDR_W-1:0]   dc_addr,
  output logic [DATA_W-1:0]   dc_wdata,
  output logic [DATA_W/8-1:0] dc_wstrb,
  output logic                dc_we,
  output logic                dc_uncached,
  input  logic                dc_resp_valid,
  input  logic [DATA_W-1:0]   dc_rdata
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_DROP  = 2'd3;

  logic [1:0]          state_q, state_d;
  logic                owner_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W/8-1:0] wstrb_q;
  logic                we_q;
  logic                uncached_q;

  // Grant is purely combinational: pipe 0 wins whenever it asks.
  logic grant0, grant1, accept;
  assign grant0 = (state_q == S_IDLE) && !flush && p0_req_valid;
  assign grant1 = (state_q == S_IDLE) && !flush && !p0_req_valid && p1_req_valid;
  assign accept = grant0 || grant1;

  // State register; reset abandons any access immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic; stray responses in IDLE/ISSUE are ignored.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept) state_d = S_ISSUE;
      S_ISSUE: begin
        if (dc_req_ready) state_d = flush ? S_DROP : S_WAIT;
        else if (flush)   state_d = S_IDLE;
      end
      S_WAIT: begin
        if (dc_resp_valid) state_d = S_IDLE;
        else if (flush)    state_d = S_DROP;
      end
      S_DROP:  if (dc_resp_valid) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Latch owner and payload on acceptance; held stable through ISSUE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner_q    <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      we_q       <= 1'b0;
      uncached_q <= 1'b0;
    end else if (accept) begin
      owner_q    <= grant1;
      addr_q     <= grant1 ? p1_addr     : p0_addr;
      wdata_q    <= grant1 ? p1_wdata    : p0_wdata;
      wstrb_q    <= grant1 ? p1_wstrb    : p0_wstrb;
      we_q       <= grant1 ? p1_we       : p0_we;
      uncached_q <= grant1 ? p1_uncached : p0_uncached;
    end
  end

  // Outputs: request in ISSUE, response forwarded to the owner only in WAIT
  // and only when the same-cycle flush has not cancelled it.
  always_comb begin
    logic fwd;
    fwd           = (state_q == S_WAIT) && dc_resp_valid && !flush;
    p0_req_ready  = grant0;
    p1_req_ready  = grant1;
    dc_req_valid  = (state_q == S_ISSUE);
    dc_addr       = addr_q;
    dc_wdata      = wdata_q;
    dc_wstrb      = wstrb_q;
    dc_we         = we_q;
    dc_uncached   = uncached_q;
    p0_resp_valid = fwd && !owner_q;
    p1_resp_valid = fwd && owner_q;
    p0_rdata      = p0_resp_valid ? dc_rdata : '0;
    p1_rdata      = p1_resp_valid ? dc_rdata : '0;
  end

endmodule

// File: tb/tb_dcache_arbiter.sv
// Directed bench for dcache_arbiter: inputs change 1ns after the rising
// edge, outputs are checked at the falling edge of the same cycle.
module tb_dcache_arbiter;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic flush = 1'b0;
  logic p0_req_valid = 1'b0, p1_req_valid = 1'b0;
  logic p0_req_ready, p1_req_ready;
  logic [ADDR_W-1:0] p0_addr = '0, p1_addr = '0;
  logic [DATA_W-1:0] p0_wdata = '0, p1_wdata = '0;
  logic [3:0] p0_wstrb = '0, p1_wstrb = '0;
  logic p0_we = 1'b0, p1_we = 1'b0, p0_uncached = 1'b0, p1_uncached = 1'b0;
  logic p0_resp_valid, p1_resp_valid;
  logic [DATA_W-1:0] p0_rdata, p1_rdata;
  logic dc_req_valid;
  logic dc_req_ready = 1'b0;
  logic [ADDR_W-1:0] dc_addr;
  logic [DATA_W-1:0] dc_wdata;
  logic [3:0] dc_wstrb;
  logic dc_we, dc_uncached;
  logic dc_resp_valid = 1'b0;
  logic [DATA_W-1:0] dc_rdata = '0;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  dcache_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .p0_req_valid(p0_req_valid), .p0_req_ready(p0_req_ready),
    .p0_addr(p0_addr), .p0_wdata(p0_wdata), .p0_wstrb(p0_wstrb),
    .p0_we(p0_we), .p0_uncached(p0_uncached),
    .p0_resp_valid(p0_resp_valid), .p0_rdata(p0_rdata),
    .p1_req_valid(p1_req_valid), .p1_req_ready(p1_req_ready),
    .p1_addr(p1_addr), .p1_wdata(p1_wdata), .p1_wstrb(p1_wstrb),
    .p1_we(p1_we), .p1_uncached(p1_uncached),
    .p1_resp_valid(p1_resp_valid), .p1_rdata(p1_rdata),
    .dc_req_valid(dc_req_valid), .dc_req_ready(dc_req_ready),
    .dc_addr(dc_addr), .dc_wdata(dc_wdata), .dc_wstrb(dc_wstrb),
    .dc_we(dc_we), .dc_uncached(dc_uncached),
    .dc_resp_valid(dc_resp_valid), .dc_rdata(dc_rdata)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // advance to 1ns after the next rising edge (input drive point)
  task automatic next();
    @(posedge clk);
    #1;
  endtask

  // settle to the falling edge of the current cycle (sample point)
  task automatic sample();
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    // ---------------- reset ----------------
    #2;
    chk("rst_dc_req_valid", dc_req_valid, 0);
    chk("rst_p0_resp", p0_resp_valid, 0);
    chk("rst_p1_resp", p1_resp_valid, 0);
    chk("rst_p0_rdata", p0_rdata, 0);
    chk("rst_dc_addr", dc_addr, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // -------- both pipes valid: p0 first, then p1 --------
    p0_req_valid = 1; p0_addr = 32'h100; p0_we = 1; p0_wdata = 32'hCAFE0001; p0_wstrb = 4'hF;
    p1_req_valid = 1; p1_addr = 32'h200;
    sample();
    chk("arb_p0_ready", p0_req_ready, 1);
    chk("arb_p1_ready", p1_req_ready, 0);
    next();
    p0_req_valid = 0; dc_req_ready = 1;
    sample();
    chk("arb_issue_valid", dc_req_valid, 1);
    chk("arb_issue_addr", dc_addr, 32'h100);
    chk("arb_issue_we", dc_we, 1);
    chk("arb_issue_wdata", dc_wdata, 32'hCAFE0001);
    chk("arb_issue_wstrb", dc_wstrb, 4'hF);
    chk("arb_p1_blocked_issue", p1_req_ready, 0);
    next();
    dc_req_ready = 0;
    sample();
    chk("arb_wait_no_req", dc_req_valid, 0);
    chk("arb_wait_no_resp", p0_resp_valid, 0);
    chk("arb_p1_blocked_wait", p1_req_ready, 0);
    next();
    dc_resp_valid = 1; dc_rdata = 32'h11111111;
    sample();
    chk("arb_p0_resp", p0_resp_valid, 1);
    chk("arb_p0_rdata", p0_rdata, 32'h11111111);
    chk("arb_p1_resp_quiet", p1_resp_valid, 0);
    chk("arb_p1_blocked_resp", p1_req_ready, 0);
    next();
    dc_resp_valid = 0;
    sample();
    chk("arb_p1_ready_after", p1_req_ready, 1);
    $display("txn p0 addr=0x100 store served; p1 accepted next");
    next();
    p1_req_valid = 0; dc_req_ready = 1;
    sample();
    chk("arb_p1_issue_addr", dc_addr, 32'h200);
    chk("arb_p1_issue_valid", dc_req_valid, 1);
    next();
    dc_req_ready = 0; dc_resp_valid = 1; dc_rdata = 32'h22222222;
    sample();
    chk("arb_p1_resp", p1_resp_valid, 1);
    chk("arb_p1_rdata", p1_rdata, 32'h22222222);
    chk("arb_p0_quiet", p0_resp_valid, 0);
    $display("txn p1 addr=0x200 load served");
    next();
    dc_resp_valid = 0;

    // -------- p1 load with dcache backpressure --------
    p1_req_valid = 1; p1_addr = 32'h80; p1_we = 0;
    sample();
    chk("bp_p1_ready", p1_req_ready, 1);
    next();
    p1_req_valid = 0;
    for (int i = 0; i < 4; i++) begin
      dc_req_ready = (i == 3);
      sample();
      chk("bp_hold_valid", dc_req_valid, 1);
      chk("bp_hold_addr", dc_addr, 32'h80);
      next();
    end
    dc_req_ready = 0; dc_resp_valid = 1; dc_rdata = 32'hDEADBEEF;
    sample();
    chk("bp_p1_resp", p1_resp_valid, 1);
    chk("bp_p1_rdata", p1_rdata, 32'hDEADBEEF);
    chk("bp_p0_resp", p0_resp_valid, 0);
    $display("txn p1 load addr=0x80 after 3 stall cycles");
    next();
    dc_resp_valid = 0;

    // -------- flush in ISSUE without handshake --------
    p0_req_valid = 1; p0_addr = 32'h300; p0_we = 0;
    sample();
    chk("fi_accept", p0_req_ready, 1);
    next();
    p0_req_valid = 0; flush = 1;
    sample();
    chk("fi_issue_valid", dc_req_valid, 1);
    next();
    flush = 0;
    sample();
    chk("fi_withdrawn", dc_req_valid, 0);
    chk("fi_state_idle", dut.state_q, 0);
    chk("fi_p0_resp", p0_resp_valid, 0);
    chk("fi_p1_resp", p1_resp_valid, 0);
    $display("txn p0 addr=0x300 withdrawn by flush in ISSUE");

    // -------- flush in IDLE blocks acceptance --------
    p0_req_valid = 1; p0_addr = 32'h340; flush = 1;
    sample();
    chk("fidle_no_ready", p0_req_ready, 0);
    next();
    flush = 0;
    sample();
    chk("fidle_state", dut.state_q, 0);
    chk("fidle_ready", p0_req_ready, 1);
    next();

    // -------- flush in WAIT, response 3 cycles later --------
    p0_req_valid = 0; dc_req_ready = 1;
    next();
    dc_req_ready = 0; flush = 1;
    sample();
    chk("fw_no_resp", p0_resp_valid, 0);
    next();
    flush = 0; p0_req_valid = 1; p0_addr = 32'h400;
    sample();
    chk("fw_drop_state", dut.state_q, 3);
    chk("fw_drop_no_ready", p0_req_ready, 0);
    next();
    flush = 1;
    sample();
    chk("fw_drop_no_ready2", p0_req_ready, 0);
    next();
    flush = 0; dc_resp_valid = 1; dc_rdata = 32'h33333333;
    sample();
    chk("fw_drop_state_kept", dut.state_q, 3);
    chk("fw_discard_p0", p0_resp_valid, 0);
    chk("fw_discard_p1", p1_resp_valid, 0);
    chk("fw_discard_rdata", p0_rdata, 0);
    next();
    dc_resp_valid = 0;
    sample();
    chk("fw_accept_after", p0_req_ready, 1);
    $display("txn p0 addr=0x340 response discarded in DROP");
    next();
    p0_req_valid = 0; dc_req_ready = 1;
    sample();
    chk("fw_new_addr", dc_addr, 32'h400);
    next();

    // -------- flush coincident with response --------
    dc_req_ready = 0; flush = 1; dc_resp_valid = 1; dc_rdata = 32'h44444444;
    sample();
    chk("fc_suppressed", p0_resp_valid, 0);
    chk("fc_rdata", p0_rdata, 0);
    next();
    flush = 0; dc_resp_valid = 0;
    sample();
    chk("fc_idle", dut.state_q, 0);
    $display("txn p0 addr=0x400 response suppressed by flush");

    // -------- reset in WAIT, then stray response --------
    p1_req_valid = 1; p1_addr = 32'h500;
    next();
    p1_req_valid = 0; dc_req_ready = 1;
    next();
    dc_req_ready = 0;
    sample();
    chk("rw_in_wait", dut.state_q, 2);
    #1 rst = 1; dc_resp_valid = 1; dc_rdata = 32'h55555555;
    #1;
    chk("rw_req_valid", dc_req_valid, 0);
    chk("rw_p1_resp", p1_resp_valid, 0);
    chk("rw_dc_addr", dc_addr, 0);
    chk("rw_state", dut.state_q, 0);
    next();
    rst = 0;
    sample();
    chk("rw_stray_p0", p0_resp_valid, 0);
    chk("rw_stray_p1", p1_resp_valid, 0);
    next();
    dc_resp_valid = 0;
    sample();
    chk("rw_stray_state", dut.state_q, 0);
    chk("rw_stray_req", dc_req_valid, 0);
    $display("txn p1 addr=0x500 abandoned by reset; stray response ignored");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/dcache_arbiter.md
DCACHE_ARBITER -- requirements
Module: dcache_arbiter

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset; port names SHALL be clk and rst.
REQ-002 Parameter: ADDR_W, default 32, address width.
REQ-003 Parameter: DATA_W, default 32, data width; the write strobe is DATA_W/8 bits.
REQ-004 clk  in  1  clock; all state updates on the rising edge.
REQ-005 rst  in  1  asynchronous active-high reset.
REQ-006 flush  in  1  pipeline flush (exception or branch redirect); cancels the in-flight access.
REQ-007 p0_req_valid, p1_req_valid  in  1 each  memory request from LSU pipe 0 (older) and pipe 1 (younger).
REQ-008 p0_req_ready, p1_req_ready  out  1 each  the request is accepted this cycle.
REQ-009 pN_addr ADDR_W, pN_wdata DATA_W, pN_wstrb DATA_W/8, pN_we 1, pN_uncached 1  in  request payload per pipe.
REQ-010 p0_resp_valid, p1_resp_valid  out  1 each  response strobe; p0_rdata, p1_rdata  out  DATA_W each.
REQ-011 dc_req_valid  out  1; dc_req_ready  in  1  dcache request handshake.
REQ-012 dc_addr, dc_wdata, dc_wstrb, dc_we, dc_uncached  out  latched payload to the dcache.
REQ-013 dc_resp_valid  in  1, dc_rdata  in  DATA_W  dcache response; every accepted request (load or store) returns exactly one dc_resp_valid pulse.

Function
REQ-014 The FSM SHALL have four states: IDLE, ISSUE, WAIT, DROP; at most one dcache access SHALL be outstanding.
REQ-015 Grant (IDLE only): pipe 0 SHALL win when both pipes request (program order); pipe 1 SHALL be granted only when p0_req_valid=0.
REQ-016 pN_req_ready SHALL be 1 only in IDLE, with flush=0, for the granted pipe; it is combinational from the valids.
REQ-017 On acceptance, the block SHALL latch the payload and the owner id, then go IDLE->ISSUE.
REQ-018 ISSUE: dc_req_valid=1 with the latched payload; the payload SHALL be stable until dc_req_ready; on handshake go ISSUE->WAIT.
REQ-019 Minimum latency: accept in cycle N, dc_req_valid in cycle N+1, response forwarded no earlier than cycle N+2.
REQ-020 WAIT: on dc_resp_valid, the owner's pN_resp_valid SHALL be 1 in the same cycle with pN_rdata=dc_rdata, then go WAIT->IDLE.
REQ-021 The non-owner resp_valid SHALL be 0; resp_valid SHALL never be 1 outside WAIT.
REQ-022 A new request SHALL be accepted no earlier than the cycle after the response cycle (back-to-back throughput is 1 access per 3 cycles minimum).
REQ-023 Flush in IDLE: no acceptance that cycle; the state is unchanged.
REQ-024 Flush in ISSUE without dc_req_ready: go to IDLE; dc_req_valid SHALL deassert next cycle (a sanctioned withdrawal).
REQ-025 Flush in ISSUE with dc_req_ready in the same cycle: the access is taken by the cache; go to DROP.
REQ-026 Flush in WAIT without dc_resp_valid: go to DROP.
REQ-027 Flush in WAIT with dc_resp_valid in the same cycle: resp_valid SHALL be suppressed; go to IDLE.
REQ-028 DROP: no acceptance; on dc_resp_valid, discard it (no pN_resp_valid) and go to IDLE; flush in DROP SHALL have no further effect.
REQ-029 dc_resp_valid arriving in IDLE or ISSUE is a protocol error; it SHALL be ignored and the block SHALL NOT change state.

Reset
REQ-030 On rst, the state SHALL go to IDLE immediately (asynchronously); the owner SHALL be 0 and the latched payload 0.
REQ-031 During and after reset: dc_req_valid=0, pN_resp_valid=0, pN_rdata=0, dc_* payload 0; pN_req_ready follows REQ-016 from the first cycle after rst deasserts.
REQ-032 Reset mid-access SHALL abandon the access; a later stray dc_resp_valid is handled per REQ-029.

Verification
REQ-033 The bench SHALL cover: both pipes valid, p0 addr 0x100 and p1 addr 0x200, dc_req_ready=1, and a response 2 cycles later -> p0 served first with dc_addr=0x100; p1 accepted in the cycle after p0's response, then dc_addr=0x200.
REQ-034 The bench SHALL cover: p1 load at 0x80 with dc_req_ready held 0 for 3 cycles -> dc_req_valid and dc_addr=0x80 held stable for 4 cycles; p1_resp_valid=1, p1_rdata=0xDEADBEEF on the response; p0_resp_valid remains 0.
REQ-035 The bench SHALL cover: flush in ISSUE with dc_req_ready=0 -> dc_req_valid=0 next cycle, state IDLE, no response to either pipe.
REQ-036 The bench SHALL cover: flush in WAIT, then dc_resp_valid 3 cycles later -> DROP state, no pN_resp_valid, and a new request accepted the cycle after the discard.
REQ-037 The bench SHALL cover: flush coincident with dc_resp_valid in WAIT -> response suppressed, IDLE the next cycle.
REQ-038 The bench SHALL cover: rst asserted in WAIT -> dc_req_valid=0 and resp_valid=0 immediately; a stray dc_resp_valid after reset is ignored.
